alu_cmd_sequencer: RTL and testbench

Sequential command front end for the 16-bit combinational ALU breadboard (ADD, SUB, MUL, DIV, MOD). It accepts operation commands over a valid/ready handshake and drives registered operands and an opcode into the breadboard. After a configurable settle time it captures `outputC` and `error`, then returns them over a valid/ready response channel. It also keeps a 32-bit accumulator, so operations can be chained.

---
 rtl/alu_cmd_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 16-bit combinational ALU breadboard: drives registered operands,
// waits SETTLE cycles, captures result/error into a response channel and maintains an accumulator.
module alu_cmd_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_use_acc,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [31:0] alu_c,
    input  logic [1:0]  alu_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_c,
    output logic [1:0]  rsp_error,
    output logic        rsp_illegal,
    output logic [31:0] acc,
    output logic [15:0] op_count
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned SETTLE_CLAMPED = (SETTLE < 1) ? 1 : ((SETTLE > 15) ? 15 : SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CLAMPED);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [3:0] OP_CLEAR = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_MUL   = 4'b0110;
    localparam logic [3:0] OP_DIV   = 4'b0111;
    localparam logic [3:0] OP_MOD   = 4'b1000;

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [CNT_W-1:0] settleCnt;

    logic             accept;
    logic             capture;
    logic             handshake;

    logic [31:0]      capC;
    logic [1:0]       capErr;
    logic             capIllegal;
    logic             accLoad;

    // Ready is gated by reset so nothing can be accepted while rst is high.
    assign cmd_ready = ~rst && (state == IDLE);

    assign accept    = (state == IDLE)  && cmd_valid;
    assign capture   = (state == DRIVE) && (settleCnt == CNT_W'(1));
    assign handshake = (state == RESP)  && rsp_ready;

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (cmd_valid) stateNext = DRIVE;
            DRIVE:   if (settleCnt == CNT_W'(1)) stateNext = RESP;
            RESP:    if (rsp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Result selection for the held opcode; accumulator follows only error-free results
    always_comb begin
        capC       = 32'h0000_0000;
        capErr     = 2'b00;
        capIllegal = 1'b0;
        accLoad    = 1'b0;
        case (alu_opcode)
            OP_CLEAR: accLoad = 1'b1;
            OP_LOAD: begin
                capC    = {16'h0000, alu_b};
                accLoad = 1'b1;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
                capC    = alu_c;
                capErr  = alu_error;
                accLoad = (alu_error == 2'b00);
            end
            default: capIllegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            settleCnt   <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_opcode  <= '0;
            rsp_valid   <= 1'b0;
            rsp_c       <= '0;
            rsp_error   <= '0;
            rsp_illegal <= 1'b0;
            acc         <= '0;
            op_count    <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                alu_a      <= cmd_use_acc ? acc[15:0] : cmd_a;
                alu_b      <= cmd_b;
                alu_opcode <= cmd_opcode;
                settleCnt  <= SETTLE_INIT;
            end else if (state == DRIVE) begin
                settleCnt <= CNT_W'(settleCnt - CNT_W'(1));
            end
            if (capture) begin
                rsp_valid   <= 1'b1;
                rsp_c       <= capC;
                rsp_error   <= capErr;
                rsp_illegal <= capIllegal;
                if (accLoad) acc <= capC;
            end
            if (handshake) begin
                rsp_valid <= 1'b0;
                op_count  <= 16'(op_count + 16'd1);
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed testbench for alu_cmd_sequencer: SETTLE=1 instance for function/throughput,
// SETTLE=3 instance for backpressure; each has a behavioural breadboard model.
module tb_alu_cmd_sequencer;

    logic        clk;
    logic        rst;
    logic        cmdValid, cmdValid3;
    logic [3:0]  cmdOpcode;
    logic [15:0] cmdA, cmdB;
    logic        cmdUseAcc;
    logic        rspReady, rspReady3;

    logic        cmdReady, cmdReady3;
    logic [15:0] aluA, aluB, aluA3, aluB3;
    logic [3:0]  aluOp, aluOp3;
    logic [31:0] aluC, aluC3;
    logic [1:0]  aluErr, aluErr3;
    logic        rspValid, rspValid3;
    logic [31:0] rspC, rspC3;
    logic [1:0]  rspError, rspError3;
    logic        rspIllegal, rspIllegal3;
    logic [31:0] acc, acc3;
    logic [15:0] opCount, opCount3;

    int errors = 0;
    int checks = 0;
    int expOps = 0;

    alu_cmd_sequencer #(.SETTLE(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_opcode(cmdOpcode),
        .cmd_a(cmdA), .cmd_b(cmdB), .cmd_use_acc(cmdUseAcc),
        .alu_a(aluA), .alu_b(aluB), .alu_opcode(aluOp), .alu_c(aluC), .alu_error(aluErr),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_c(rspC), .rsp_error(rspError),
        .rsp_illegal(rspIllegal), .acc(acc), .op_count(opCount)
    );

    alu_cmd_sequencer #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmdValid3), .cmd_ready(cmdReady3), .cmd_opcode(cmdOpcode),
        .cmd_a(cmdA), .cmd_b(cmdB), .cmd_use_acc(cmdUseAcc),
        .alu_a(aluA3), .alu_b(aluB3), .alu_opcode(aluOp3), .alu_c(aluC3), .alu_error(aluErr3),
        .rsp_valid(rspValid3), .rsp_ready(rspReady3), .rsp_c(rspC3), .rsp_error(rspError3),
        .rsp_illegal(rspIllegal3), .acc(acc3), .op_count(opCount3)
    );

    // Breadboard model: {error, outputC}; unsigned carry/borrow flags overflow
    function automatic logic [33:0] breadboard(input logic [15:0] a, input logic [15:0] b,
                                               input logic [3:0] op);
        logic [31:0] c;
        logic [1:0]  e;
        logic [16:0] s;
        c = 32'h0;
        e = 2'b00;
        s = 17'h0;
        case (op)
            4'b0100: begin s = 17'(a) + 17'(b); c = 32'(s); e[0] = s[16]; end
            4'b0101: begin c = 32'(16'(a - b)); e[0] = (a < b); end
            4'b0110: c = 32'(a) * 32'(b);
            4'b0111: if (b == 16'h0) e = 2'b10; else c = 32'(a / b);
            4'b1000: if (b == 16'h0) e = 2'b10; else c = 32'(a % b);
            default: c = 32'h0;
        endcase
        return {e, c};
    endfunction

    always_comb {aluErr, aluC}   = breadboard(aluA, aluB, aluOp);
    always_comb {aluErr3, aluC3} = breadboard(aluA3, aluB3, aluOp3);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one command on the SETTLE=1 instance, wait for the response, complete the handshake
    task automatic runOp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ua, output int lat, output logic [31:0] c,
                         output logic [1:0] e, output logic ill);
        @(negedge clk);
        cmdValid = 1'b1; cmdOpcode = op; cmdA = a; cmdB = b; cmdUseAcc = ua;
        @(posedge clk); #1;
        cmdValid = 1'b0;
        lat = 0;
        while (rspValid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat >= 20) begin
            errors++;
            $display("FAIL rsp_timeout op=%b got no rsp_valid within 20 cycles, required within 1", op);
        end
        c = rspC; e = rspError; ill = rspIllegal;
        @(posedge clk); #1;
        expOps++;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmdValid = 1'b1; cmdValid3 = 1'b0; cmdOpcode = 4'b0100;
        cmdA = 16'd1; cmdB = 16'd1; cmdUseAcc = 1'b0; rspReady = 1'b1; rspReady3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cmdReady !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cmdReady); end
        checks++;
        if ({rspValid, rspC, rspError, rspIllegal} !== 36'h0) begin
            errors++; $display("FAIL reset_rsp got v=%b c=%h e=%b i=%b exp all 0", rspValid, rspC, rspError, rspIllegal);
        end
        checks++;
        if ({aluA, aluB, aluOp, acc, opCount} !== 84'h0) begin
            errors++; $display("FAIL reset_regs got a=%h b=%h op=%h acc=%h cnt=%h exp all 0", aluA, aluB, aluOp, acc, opCount);
        end
        @(negedge clk);
        rst = 1'b0; cmdValid = 1'b0;
        #1;
        checks++;
        if (cmdReady !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", cmdReady); end
        expOps = 0;
    endtask

    task automatic test_alu_ops;
        logic [3:0]  ops  [5] = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000};
        logic [15:0] as   [5] = '{16'd17409, 16'd8194, 16'd1024, 16'd16384, 16'd16391};
        logic [15:0] bs   [5] = '{16'd4616, 16'd6144, 16'd4097, 16'd1024, 16'd1024};
        logic [31:0] exps [5] = '{32'd22025, 32'd2050, 32'h00400400, 32'd16, 32'd7};
        int lat; logic [31:0] c; logic [1:0] e; logic ill;
        for (int i = 0; i < 5; i++) begin
            runOp(ops[i], as[i], bs[i], 1'b0, lat, c, e, ill);
            checks++;
            if (lat != 1) begin errors++; $display("FAIL op%0d_latency got=%0d exp=1", i, lat); end
            checks++;
            if (c !== exps[i]) begin errors++; $display("FAIL op%0d_result got=%h exp=%h", i, c, exps[i]); end
            checks++;
            if (e !== 2'b00 || ill !== 1'b0) begin errors++; $display("FAIL op%0d_flags got e=%b i=%b exp 00/0", i, e, ill); end
        end
        checks++;
        if (opCount !== 16'd5) begin errors++; $display("FAIL op_count_5 got=%0d exp=5", opCount); end
        checks++;
        if (acc !== 32'd7) begin errors++; $display("FAIL acc_after_mod got=%h exp=7", acc); end
    endtask

    task automatic test_acc_chain;
        int lat; logic [31:0] c; logic [1:0] e; logic ill;
        runOp(4'b0010, 16'hABCD, 16'd5, 1'b0, lat, c, e, ill);
        checks++;
        if (acc !== 32'd5 || c !== 32'd5) begin errors++; $display("FAIL chain_load got acc=%h c=%h exp 5/5", acc, c); end
        runOp(4'b0110, 16'd9999, 16'd3, 1'b1, lat, c, e, ill);
        checks++;
        if (aluA !== 16'd5) begin errors++; $display("FAIL chain_use_acc got alu_a=%h exp=5", aluA); end
        checks++;
        if (acc !== 32'd15) begin errors++; $display("FAIL chain_mul got acc=%h exp=f", acc); end
        runOp(4'b0100, 16'd0, 16'd1, 1'b1, lat, c, e, ill);
        checks++;
        if (acc !== 32'd16 || c !== 32'd16) begin errors++; $display("FAIL chain_add got acc=%h c=%h exp 10/10", acc, c); end
    endtask

    task automatic test_acc_width;
        int lat; logic [31:0] c; logic [1:0] e; logic ill;
        runOp(4'b0110, 16'd1024, 16'd4097, 1'b0, lat, c, e, ill);
        runOp(4'b0100, 16'hFFFF, 16'd0, 1'b1, lat, c, e, ill);
        checks++;
        if (aluA !== 16'h0400 || c !== 32'h400 || acc !== 32'h400) begin
            errors++; $display("FAIL acc_upper_drop got alu_a=%h c=%h acc=%h exp 0400/400/400", aluA, c, acc);
        end
        runOp(4'b0010, 16'd0, 16'd16, 1'b0, lat, c, e, ill);
    endtask

    task automatic test_error;
        int lat; logic [31:0] c; logic [1:0] e; logic ill;
        runOp(4'b0111, 16'd100, 16'd0, 1'b0, lat, c, e, ill);
        checks++;
        if (e !== 2'b10 || ill !== 1'b0) begin errors++; $display("FAIL div0_error got e=%b i=%b exp 10/0", e, ill); end
        checks++;
        if (acc !== 32'd16) begin errors++; $display("FAIL div0_acc got=%h exp=10", acc); end
        runOp(4'b1111, 16'd3, 16'd4, 1'b0, lat, c, e, ill);
        checks++;
        if (ill !== 1'b1 || c !== 32'h0 || e !== 2'b00) begin
            errors++; $display("FAIL illegal_rsp got i=%b c=%h e=%b exp 1/0/00", ill, c, e);
        end
        checks++;
        if (acc !== 32'd16) begin errors++; $display("FAIL illegal_acc got=%h exp=10", acc); end
        runOp(4'b0100, 16'hFFFF, 16'd1, 1'b0, lat, c, e, ill);
        checks++;
        if (e !== 2'b01 || c !== 32'h0001_0000 || acc !== 32'd16) begin
            errors++; $display("FAIL add_ovf got e=%b c=%h acc=%h exp 01/10000/10", e, c, acc);
        end
        runOp(4'b0001, 16'd5, 16'd5, 1'b0, lat, c, e, ill);
        checks++;
        if (acc !== 32'h0 || c !== 32'h0 || ill !== 1'b0) begin
            errors++; $display("FAIL clear got acc=%h c=%h i=%b exp 0/0/0", acc, c, ill);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        cmdValid = 1'b1; cmdOpcode = 4'b0010; cmdA = 16'd0; cmdB = 16'd7; cmdUseAcc = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rspValid !== 1'((k % 3) == 1)) begin
                errors++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, rspValid, (k % 3) == 1);
            end
        end
        @(negedge clk);
        cmdValid = 1'b0;
        expOps += 3;
        checks++;
        if (opCount !== 16'(expOps) || acc !== 32'd7) begin
            errors++; $display("FAIL b2b_count got cnt=%0d acc=%h exp %0d/7", opCount, acc, expOps);
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        rspReady3 = 1'b0; cmdValid3 = 1'b1; cmdOpcode = 4'b0100; cmdA = 16'd2; cmdB = 16'd3; cmdUseAcc = 1'b0;
        @(posedge clk); #1;
        cmdA = 16'd100;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            checks++;
            if (rspValid3 !== 1'(k >= 3) || cmdReady3 !== 1'b0) begin
                errors++; $display("FAIL bp_handshake k=%0d got v=%b rdy=%b exp v=%b rdy=0", k, rspValid3, cmdReady3, k >= 3);
            end
            checks++;
            if (aluA3 !== 16'd2 || (k >= 3 && rspC3 !== 32'd5)) begin
                errors++; $display("FAIL bp_stable k=%0d got alu_a=%h c=%h exp 2/5", k, aluA3, rspC3);
            end
        end
        @(negedge clk);
        cmdValid3 = 1'b0; rspReady3 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rspValid3 !== 1'b0 || cmdReady3 !== 1'b1 || opCount3 !== 16'd1) begin
            errors++; $display("FAIL bp_release got v=%b rdy=%b cnt=%0d exp 0/1/1", rspValid3, cmdReady3, opCount3);
        end
        rspReady3 = 1'b0;
    endtask

    task automatic test_reset_midop;
        @(negedge clk);
        cmdValid = 1'b1; cmdOpcode = 4'b0100; cmdA = 16'd1; cmdB = 16'd1; cmdUseAcc = 1'b0;
        @(posedge clk); #1;
        cmdValid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rspValid !== 1'b0 || acc !== 32'h0 || opCount !== 16'h0) begin
            errors++; $display("FAIL midop_reset got v=%b acc=%h cnt=%0d exp 0/0/0", rspValid, acc, opCount);
        end
        @(negedge clk);
        rst = 1'b0;
        expOps = 0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if (rspValid !== 1'b0 || cmdReady !== 1'b1) begin
                errors++; $display("FAIL midop_abandon got v=%b rdy=%b exp 0/1", rspValid, cmdReady);
            end
        end
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] c; logic [1:0] e; logic ill;
        @(negedge clk);
        force dut.op_count = 16'hFFFF;
        @(negedge clk);
        release dut.op_count;
        #1;
        checks++;
        if (opCount !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset got=%h exp=ffff", opCount); end
        runOp(4'b0010, 16'd0, 16'd9, 1'b0, lat, c, e, ill);
        checks++;
        if (opCount !== 16'h0000 || acc !== 32'd9) begin
            errors++; $display("FAIL wrap got cnt=%h acc=%h exp 0000/9", opCount, acc);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_acc_chain();
        test_acc_width();
        test_error();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
